// File: rtl/dac7611_arbiter.sv
// Two-requester round-robin front end for the DAC7611 serial DAC: grants a 12-bit code,
// shifts it MSB-first at clk_X4/4, pulses LD, and services latched clear requests between frames.
module dac7611_arbiter #(
    parameter int unsigned GAP_CYC  = 2,
    parameter int unsigned LD_CYC   = 2,
    parameter int unsigned CLR_CYC  = 2,
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic        clk_X4,
    input  logic        rst,
    input  logic        req_a,
    input  logic [11:0] code_a,
    output logic        ack_a,
    input  logic        req_b,
    input  logic [11:0] code_b,
    output logic        ack_b,
    input  logic        clr_req,
    output logic        busy,
    output logic        frame_done,
    output logic        CLK_3,
    output logic        SDI_4,
    output logic        LD_5,
    output logic        CLR_6
);

    // Handshake: a requester raises req with its code stable and holds both until it sees
    // the one-cycle ack; the code is captured on the ack cycle. Holding req past the ack
    // makes the requester eligible again at the next IDLE, subject to round-robin.

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_GAP   = 3'd2,
        ST_LOAD  = 3'd3,
        ST_CLEAR = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);
    localparam logic [7:0] LD_LAST   = 8'(LD_CYC - 1);
    localparam logic [7:0] CLR_LAST  = 8'(CLR_CYC - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  wait_q, wait_d;
    logic [11:0] shreg_q, shreg_d;
    logic        last_b_q, last_b_d;
    logic        clr_pend_q, clr_pend_d;
    logic        hold_frame_q, hold_frame_d;
    logic        ack_a_q, ack_a_d;
    logic        ack_b_q, ack_b_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        sclk_q, sclk_d;
    logic        sdi_q, sdi_d;
    logic        ld_q, ld_d;
    logic        clr_q, clr_d;
    logic        grant_b;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_d        = bit_q;
        wait_d       = wait_q;
        shreg_d      = shreg_q;
        last_b_d     = last_b_q;
        clr_pend_d   = clr_pend_q | clr_req;
        hold_frame_d = hold_frame_q;
        grant_b      = 1'b0;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        busy_d       = (state_q != ST_IDLE);
        frame_done_d = 1'b0;
        sclk_d       = 1'b1;
        sdi_d        = 1'b0;
        ld_d         = 1'b1;
        clr_d        = 1'b1;

        case (state_q)
            ST_IDLE: begin
                grant_b = req_b && (!req_a || !last_b_q);
                // A clear arriving on the cycle a pending one is consumed stays pending.
                if (clr_pend_q) begin
                    state_d    = ST_CLEAR;
                    wait_d     = 8'd0;
                    clr_pend_d = clr_req;
                end else if (clr_req) begin
                    state_d    = ST_CLEAR;
                    wait_d     = 8'd0;
                    clr_pend_d = 1'b0;
                end else if (req_a || req_b) begin
                    state_d  = ST_SHIFT;
                    phase_d  = 2'd0;
                    bit_d    = 4'd0;
                    last_b_d = grant_b;
                    ack_a_d  = !grant_b;
                    ack_b_d  = grant_b;
                    shreg_d  = grant_b ? code_b : code_a;
                end
            end
            ST_SHIFT: begin
                // Data is set up on the low half of SCLK so the DAC samples mid-bit.
                sclk_d  = phase_q[1];
                sdi_d   = shreg_q[11];
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    shreg_d = {shreg_q[10:0], 1'b0};
                    if (bit_q == 4'd11) begin
                        state_d = ST_GAP;
                        wait_d  = 8'd0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_GAP: begin
                if (wait_q == GAP_LAST) begin
                    state_d = ST_LOAD;
                    wait_d  = 8'd0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_LOAD: begin
                ld_d = 1'b0;
                if (wait_q == LD_LAST) begin
                    state_d      = ST_HOLD;
                    wait_d       = 8'd0;
                    hold_frame_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_CLEAR: begin
                clr_d = 1'b0;
                if (wait_q == CLR_LAST) begin
                    state_d      = ST_HOLD;
                    wait_d       = 8'd0;
                    hold_frame_d = 1'b0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_HOLD: begin
                frame_done_d = hold_frame_q && (wait_q == 8'd0);
                if (wait_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    wait_d  = 8'd0;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge clk_X4) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= 2'd0;
            bit_q        <= 4'd0;
            wait_q       <= 8'd0;
            shreg_q      <= 12'd0;
            last_b_q     <= 1'b1;
            clr_pend_q   <= 1'b0;
            hold_frame_q <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            sclk_q       <= 1'b1;
            sdi_q        <= 1'b0;
            ld_q         <= 1'b1;
            clr_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            wait_q       <= wait_d;
            shreg_q      <= shreg_d;
            last_b_q     <= last_b_d;
            clr_pend_q   <= clr_pend_d;
            hold_frame_q <= hold_frame_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            sclk_q       <= sclk_d;
            sdi_q        <= sdi_d;
            ld_q         <= ld_d;
            clr_q        <= clr_d;
        end
    end

    assign ack_a      = ack_a_q;
    assign ack_b      = ack_b_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign CLK_3      = sclk_q;
    assign SDI_4      = sdi_q;
    assign LD_5       = ld_q;
    assign CLR_6      = clr_q;

endmodule

// File: tb/tb_dac7611_arbiter.sv
// Bench for dac7611_arbiter: a pin monitor rebuilds each shifted word at its LD fall and
// compares it with the expected {requester, code} queue; event cycles are checked against frame timing.
module tb_dac7611_arbiter;

    logic        clk_X4 = 1'b1;
    logic        rst = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0, clr_req = 1'b0;
    logic [11:0] code_a = 12'd0, code_b = 12'd0;
    logic        ack_a, ack_b, busy, frame_done, CLK_3, SDI_4, LD_5, CLR_6;

    logic        p_req_a = 1'b0, p_req_b = 1'b0, p_clr_req = 1'b0;
    logic [11:0] p_code_a = 12'd0, p_code_b = 12'd0;
    logic        p_ack_a, p_ack_b, p_busy, p_frame_done, p_clk, p_sdi, p_ld, p_clr;

    always #5 clk_X4 = ~clk_X4;

    dac7611_arbiter u_dut (
        .clk_X4(clk_X4), .rst(rst),
        .req_a(req_a), .code_a(code_a), .ack_a(ack_a),
        .req_b(req_b), .code_b(code_b), .ack_b(ack_b),
        .clr_req(clr_req), .busy(busy), .frame_done(frame_done),
        .CLK_3(CLK_3), .SDI_4(SDI_4), .LD_5(LD_5), .CLR_6(CLR_6)
    );

    dac7611_arbiter #(.GAP_CYC(1), .LD_CYC(3), .CLR_CYC(2), .HOLD_CYC(1)) u_dut_p (
        .clk_X4(clk_X4), .rst(rst),
        .req_a(p_req_a), .code_a(p_code_a), .ack_a(p_ack_a),
        .req_b(p_req_b), .code_b(p_code_b), .ack_b(p_ack_b),
        .clr_req(p_clr_req), .busy(p_busy), .frame_done(p_frame_done),
        .CLK_3(p_clk), .SDI_4(p_sdi), .LD_5(p_ld), .CLR_6(p_clr)
    );

    logic [12:0] exp_q[$];
    int          n_chk = 0, n_bad = 0;
    int          cyc = 0;
    bit          hold_req = 1'b0;

    // main-instance monitor state
    logic [11:0] word;
    logic        cur_who;
    int          nrise, first_rise, last_rise, ld_fall, ld_rise, fd_cyc;
    int          clr_fall, clr_rise, busy_fall, busy_rise;
    int          ack_t[$];
    logic        ack_w[$];
    logic        prev_clk = 1'b1, prev_ld = 1'b1, prev_clr = 1'b1, prev_busy = 1'b0;

    // parameterised-instance monitor state
    logic [11:0] p_word;
    int          p_nrise, p_ld_fall, p_ld_rise, p_fd_cyc;
    int          p_ack_t[$];
    logic        prev_p_clk = 1'b1, prev_p_ld = 1'b1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h) at cyc=%0d", tag, got, got, exp, exp, cyc);
        end
    endtask

    task automatic clear_mon();
        word = 12'd0; cur_who = 1'b0; nrise = 0;
        first_rise = -1; last_rise = -1; ld_fall = -1; ld_rise = -1; fd_cyc = -1;
        clr_fall = -1; clr_rise = -1; busy_fall = -1; busy_rise = -1;
        ack_t.delete(); ack_w.delete();
        p_word = 12'd0; p_nrise = 0; p_ld_fall = -1; p_ld_rise = -1; p_fd_cyc = -1;
        p_ack_t.delete();
    endtask

    task automatic sample();
        cyc++;
        if (ack_a && ack_b) chk("ack_both", 1, 0);
        if (ack_a || ack_b) begin
            cur_who = ack_b;
            ack_t.push_back(cyc);
            ack_w.push_back(ack_b);
        end
        if (!prev_clk && CLK_3) begin
            word = {word[10:0], SDI_4};
            nrise++;
            if (first_rise < 0) first_rise = cyc;
            last_rise = cyc;
        end
        if (prev_ld && !LD_5) begin
            ld_fall = cyc;
            if (exp_q.size() == 0) chk("sb_unexpected_frame", 1, 0);
            else chk("sb_word", int'({cur_who, word}), int'(exp_q.pop_front()));
            chk("sclk_rises", nrise, 12);
            nrise = 0;
        end
        if (!prev_ld && LD_5) ld_rise = cyc;
        if (frame_done) fd_cyc = cyc;
        if (prev_clr && !CLR_6) clr_fall = cyc;
        if (!prev_clr && CLR_6) clr_rise = cyc;
        if (prev_busy && !busy) busy_fall = cyc;
        if (!prev_busy && busy) busy_rise = cyc;
        prev_clk = CLK_3; prev_ld = LD_5; prev_clr = CLR_6; prev_busy = busy;

        if (p_ack_b) p_ack_t.push_back(cyc);
        if (!prev_p_clk && p_clk) begin
            p_word = {p_word[10:0], p_sdi};
            p_nrise++;
        end
        if (prev_p_ld && !p_ld) begin
            if (p_ld_fall < 0) p_ld_fall = cyc;
            chk("p_word", int'(p_word), 12'h9C1);
            chk("p_sclk_rises", p_nrise, 12);
            p_nrise = 0;
        end
        if (!prev_p_ld && p_ld && p_ld_rise < 0) p_ld_rise = cyc;
        if (p_frame_done && p_fd_cyc < 0) p_fd_cyc = cyc;
        prev_p_clk = p_clk; prev_p_ld = p_ld;
    endtask

    // Outputs change on the negedge; sample and drive on the posedge.
    task automatic tick();
        @(posedge clk_X4);
        sample();
        if (!hold_req) begin
            if (ack_a) req_a = 1'b0;
            if (ack_b) req_b = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; clr_req = 1'b0; p_req_b = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        int t0, t1;
        clear_mon();

        // reset values
        do_reset();
        chk("rst_clk", CLK_3, 1); chk("rst_sdi", SDI_4, 0);
        chk("rst_ld", LD_5, 1);   chk("rst_clr", CLR_6, 1);
        chk("rst_ack_a", ack_a, 0); chk("rst_ack_b", ack_b, 0);
        chk("rst_busy", busy, 0); chk("rst_fd", frame_done, 0);

        // single A frame, alternating bit pattern
        clear_mon();
        exp_q.push_back({1'b0, 12'hAAA});
        req_a = 1'b1; code_a = 12'hAAA;
        t0 = cyc + 1;
        while (cyc < t0 + 70) tick();
        chk("s_ack_cnt", ack_t.size(), 1);
        if (ack_t.size() > 0) chk("s_ack_cyc", ack_t[0] - t0, 0);
        chk("s_first_rise", first_rise - t0, 3);
        chk("s_last_rise", last_rise - t0, 47);
        chk("s_ld_fall", ld_fall - t0, 51);
        chk("s_ld_rise", ld_rise - t0, 53);
        chk("s_fd", fd_cyc - t0, 53);
        chk("s_busy_rise", busy_rise - t0, 1);
        chk("s_busy_fall", busy_fall - t0, 57);

        // fairness with both requesters held
        do_reset();
        clear_mon();
        for (int i = 0; i < 4; i++) exp_q.push_back((i % 2 == 0) ? {1'b0, 12'h123} : {1'b1, 12'hFED});
        hold_req = 1'b1; req_a = 1'b1; req_b = 1'b1; code_a = 12'h123; code_b = 12'hFED;
        t0 = cyc + 1;
        while (cyc < t0 + 171) tick();
        req_a = 1'b0; req_b = 1'b0; hold_req = 1'b0;
        repeat (70) tick();
        chk("rr_ack_cnt", ack_t.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_t.size()) begin
                chk("rr_ack_cyc", ack_t[i] - t0, 57 * i);
                chk("rr_ack_who", int'(ack_w[i]), i % 2);
            end
        end

        // clear and request together in IDLE
        clear_mon();
        exp_q.push_back({1'b0, 12'h5A3});
        clr_req = 1'b1; req_a = 1'b1; code_a = 12'h5A3;
        t0 = cyc + 1;
        tick();
        clr_req = 1'b0;
        while (cyc < t0 + 70) tick();
        chk("cp_clr_fall", clr_fall - t0, 1);
        chk("cp_clr_rise", clr_rise - t0, 3);
        chk("cp_ack_cnt", ack_t.size(), 1);
        if (ack_t.size() > 0) chk("cp_ack_cyc", ack_t[0] - t0, 7);
        chk("cp_ld_fall", ld_fall - t0, 58);
        chk("cp_fd", fd_cyc - t0, 60);

        // clear arriving mid-frame is deferred
        clear_mon();
        exp_q.push_back({1'b0, 12'h3C9});
        req_a = 1'b1; code_a = 12'h3C9;
        t0 = cyc + 1;
        while (cyc < t0 + 19) tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        while (cyc < t0 + 70) tick();
        chk("cd_ld_fall", ld_fall - t0, 51);
        chk("cd_fd", fd_cyc - t0, 53);
        chk("cd_clr_fall", clr_fall - t0, 58);
        chk("cd_clr_rise", clr_rise - t0, 60);

        // reset mid-frame drops the frame and the pending clear
        clear_mon();
        hold_req = 1'b1; req_a = 1'b1; code_a = 12'h0F0;
        t0 = cyc + 1;
        while (cyc < t0 + 9) tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        while (cyc < t0 + 29) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_no_ld", ld_fall, -1);
        clear_mon();
        tick();
        chk("rm_clk", CLK_3, 1); chk("rm_sdi", SDI_4, 0);
        chk("rm_ld", LD_5, 1);   chk("rm_clr", CLR_6, 1);
        chk("rm_busy", busy, 0); chk("rm_reack", ack_a, 1);
        req_a = 1'b0; hold_req = 1'b0;
        exp_q.push_back({1'b0, 12'h0F0});
        t1 = t0 + 31;
        while (cyc < t1 + 70) tick();
        chk("rm_ld_fall", ld_fall - t1, 51);
        chk("rm_no_clr", clr_fall, -1);

        // short-timing instance, B frames back to back
        do_reset();
        clear_mon();
        p_req_b = 1'b1; p_code_b = 12'h9C1;
        t0 = cyc + 1;
        while (cyc < t0 + 54) tick();
        p_req_b = 1'b0;
        repeat (60) tick();
        chk("p_ack_cnt", p_ack_t.size(), 2);
        if (p_ack_t.size() > 1) begin
            chk("p_ack0", p_ack_t[0] - t0, 0);
            chk("p_ack1", p_ack_t[1] - t0, 54);
        end
        chk("p_ld_fall", p_ld_fall - t0, 50);
        chk("p_ld_rise", p_ld_rise - t0, 53);
        chk("p_fd", p_fd_cyc - t0, 53);

        chk("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
